// File: rtl/pulse_level_encoder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pulse_level_encoder_if : strobe-in / level-out bundle for pulse_level_encoder
// Rev 1.0
// ----------------------------------------------------------------------------
interface pulse_level_encoder_if #(
  parameter int PEND_W = 3
);
  logic              pulse_in;
  logic              ovf_clr;
  logic              data_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output pulse_in,
    output ovf_clr,
    input  data_out,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  pulse_in,
    input  ovf_clr,
    output data_out,
    output busy,
    output pending,
    output overflow
  );
endinterface
`default_nettype wire

// File: rtl/pulse_level_encoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pulse_level_encoder : one fixed high window plus guaranteed low gap per strobe,
//                       with a saturating queue for strobes that arrive mid-window
// Rev 1.0
// ----------------------------------------------------------------------------
module pulse_level_encoder #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pulse_level_encoder_if.slave  bus
);

  localparam int MAX_PHASE = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CNT_W     = $clog2(MAX_PHASE + 1);

  localparam logic [CNT_W-1:0]  HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LOW_LAST  = CNT_W'(LOW_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              data_out_q;
  logic [PEND_W-1:0] pending_q;
  logic [PEND_W-1:0] pending_d;
  logic              overflow_q;
  logic              overflow_d;

  logic decide;
  logic start;
  logic drop;

  always_comb begin
    decide     = (state_q == IDLE) || ((state_q == LOW) && (cnt_q == LOW_LAST));
    start      = decide && ((pending_q != '0) || bus.pulse_in);
    pending_d  = pending_q;
    drop       = 1'b0;
    // A start with work queued pops one event; a strobe in that same cycle
    // pushes one back, so the count only moves when the strobe is absent.
    if (start && (pending_q != '0)) begin
      if (!bus.pulse_in) begin
        pending_d = pending_q - PEND_W'(1);
      end
    end else if (!start && bus.pulse_in) begin
      if (pending_q == PEND_MAX) begin
        drop = 1'b1;
      end else begin
        pending_d = pending_q + PEND_W'(1);
      end
    end
    if (drop) begin
      overflow_d = 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_out_q <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (start) begin
            state_q    <= HIGH;
            data_out_q <= 1'b1;
          end
        end
        HIGH: begin
          if (cnt_q == HIGH_LAST) begin
            state_q    <= LOW;
            cnt_q      <= '0;
            data_out_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        LOW: begin
          if (cnt_q == LOW_LAST) begin
            cnt_q <= '0;
            // Back-to-back windows skip IDLE entirely; the low gap already elapsed.
            if (start) begin
              state_q    <= HIGH;
              data_out_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          cnt_q      <= '0;
          data_out_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_level_encoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pulse_level_encoder : scoreboard bench, window schedule reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pulse_level_encoder;

  localparam int H    = 4;
  localparam int L    = 2;
  localparam int PW   = 3;
  localparam int MAXP = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pulse_level_encoder_if #(.PEND_W(PW)) bus ();

  pulse_level_encoder #(
    .HIGH_CYCLES(H),
    .LOW_CYCLES (L),
    .PEND_W     (PW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int            cyc;
    logic          d;
    logic          b;
    logic [PW-1:0] p;
    logic          o;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: the list of cycles on which each accepted event's window starts.
  int   starts[$];
  logic ovf_m;
  int   t;

  function automatic int pend_at(int c);
    int n = 0;
    foreach (starts[i]) if (starts[i] > c) n++;
    return n;
  endfunction

  function automatic bit in_win(int c, int len);
    bit hit = 1'b0;
    foreach (starts[i]) if ((starts[i] <= c) && (c < starts[i] + len)) hit = 1'b1;
    return hit;
  endfunction

  task automatic chk(string name, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic model_step(bit pulse, bit clr);
    int   p;
    bit   pop_next;
    bit   drop;
    int   nxt;
    exp_t e;
    p        = pend_at(t);
    pop_next = 1'b0;
    drop     = 1'b0;
    foreach (starts[i]) if (starts[i] == t + 1) pop_next = 1'b1;
    if (pulse) begin
      if ((p < MAXP) || pop_next) begin
        nxt = t + 1;
        if ((starts.size() > 0) && (starts[$] + H + L > nxt)) nxt = starts[$] + H + L;
        starts.push_back(nxt);
      end else begin
        drop = 1'b1;
      end
    end
    if (drop)     ovf_m = 1'b1;
    else if (clr) ovf_m = 1'b0;
    e.cyc = t + 1;
    e.d   = in_win(t + 1, H);
    e.b   = in_win(t + 1, H + L);
    e.p   = PW'(pend_at(t + 1));
    e.o   = ovf_m;
    sbq.push_back(e);
    while ((starts.size() > 1) && (starts[0] + H + L < t)) void'(starts.pop_front());
  endtask

  // Called at posedge+1 of cycle t; returns at posedge+1 of cycle t+1.
  task automatic step(bit pulse, bit clr);
    bus.pulse_in = pulse;
    bus.ovf_clr  = clr;
    model_step(pulse, clr);
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // Assert reset between edges and check that the outputs clear without a clock.
  task automatic reset_mid();
    exp_t e;
    bus.pulse_in = 1'b0;
    bus.ovf_clr  = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_data_out", int'(bus.data_out), 0);
    chk("async_rst_busy",     int'(bus.busy),     0);
    chk("async_rst_pending",  int'(bus.pending),  0);
    chk("async_rst_overflow", int'(bus.overflow), 0);
    starts.delete();
    ovf_m = 1'b0;
    e.cyc = t + 1;
    e.d   = 1'b0;
    e.b   = 1'b0;
    e.p   = '0;
    e.o   = 1'b0;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    t++;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while ((sbq.size() > 0) && (sbq[0].cyc <= t)) begin
        e = sbq.pop_front();
        chk($sformatf("data_out@%0d", e.cyc), int'(bus.data_out), int'(e.d));
        chk($sformatf("busy@%0d",     e.cyc), int'(bus.busy),     int'(e.b));
        chk($sformatf("pending@%0d",  e.cyc), int'(bus.pending),  int'(e.p));
        chk($sformatf("overflow@%0d", e.cyc), int'(bus.overflow), int'(e.o));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n        = 1'b1;
    bus.pulse_in = 1'b0;
    bus.ovf_clr  = 1'b0;
    ovf_m        = 1'b0;
    t            = 0;
    #1;
    rst_n = 1'b0;
    #2;
    chk("reset_data_out", int'(bus.data_out), 0);
    chk("reset_busy",     int'(bus.busy),     0);
    chk("reset_pending",  int'(bus.pending),  0);
    chk("reset_overflow", int'(bus.overflow), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single strobe, then a burst of three.
    idle(10);
    step(1'b1, 1'b0);
    idle(12);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    idle(24);

    // Ten-strobe storm saturates the queue; then a lone clear.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    idle(3);
    step(1'b0, 1'b1);
    idle(2);
    // Clear coinciding with dropped strobes must leave overflow set.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    idle(70);

    // Reset mid-window with three queued, then a clean single strobe.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    reset_mid();
    idle(5);
    step(1'b1, 1'b0);
    idle(10);

    // Strobe landing exactly on the final low cycle chains without an idle gap.
    step(1'b1, 1'b0);
    idle(5);
    step(1'b1, 1'b0);
    idle(12);

    for (int blk = 0; blk < 15; blk++) begin
      int dens;
      dens = $urandom_range(0, 100);
      for (int i = 0; i < 200; i++)
        step(($urandom_range(0, 99) < dens), ($urandom_range(0, 99) < 4));
      if (blk == 7) reset_mid();
    end
    idle(80);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
